uart_dbg_bridge: RTL and testbench

- Host-side front end for the debug module: converts a UART 8N1 byte stream into debug commands (cmd/addr/data) and returns the debug read data over UART.
- Sits directly upstream of the core's debug port; its dbg_* outputs feed the debug command inputs and it consumes debug data/ready.
- Contains a UART receiver, a UART transmitter, a frame parser FSM, a command-issue handshake and a response serializer.

---
 rtl/uart_dbg_bridge.sv | 196 +++++++++++++++++++
 tb/tb_uart_dbg_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dbg_bridge.sv
// UART-to-debug bridge: 9-byte 8N1 command frames in, one debug command out,
// and a 5-byte status/data response returned over the TX line.
module uart_dbg_bridge #(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 115200,
    parameter int DBG_TIMEOUT    = 1024,
    parameter int FRAME_GAP_BITS = 20
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i,
    output logic        busy_o
);
    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST    = 32'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] GAP_LIMIT    = 32'(FRAME_GAP_BITS * CLKS_PER_BIT);
    localparam logic [31:0] TMO_LAST     = 32'(DBG_TIMEOUT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, RECV, ISSUE, RESP} state_t;

    rx_state_t   rx_state, rx_state_next;
    logic        rx_meta, rx_sync, rx_prev;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_tick, rx_done, rx_ferr;

    state_t      state, state_next;
    logic [3:0]  byte_cnt;
    logic [7:0]  cmd_r;
    logic [31:0] addr_r, data_r, gap_cnt, tmo_cnt, tx_cnt, rsp_data;
    logic [9:0]  tx_shift;
    logic [3:0]  tx_bit;
    logic [2:0]  tx_idx;
    logic [7:0]  next_tx_byte;
    logic        gap_expired, issue_ok, issue_tmo, tx_tick, tx_last;

    // Receiver: rx_done/rx_ferr pulse in the cycle the stop bit is sampled,
    // with the completed byte already sitting in rx_shift.
    always_comb begin
        rx_state_next = rx_state;
        rx_done       = 1'b0;
        rx_ferr       = 1'b0;
        rx_tick       = (rx_cnt == BIT_LAST);
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_sync;
                    rx_ferr       = !rx_sync;
                end
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_next;
            if (rx_state == RX_IDLE || rx_state_next != rx_state || rx_tick) rx_cnt <= '0;
            else rx_cnt <= rx_cnt + 32'd1;
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        gap_expired = (state == RECV) && (gap_cnt > GAP_LIMIT);
        issue_ok    = (state == ISSUE) && dbg_ready_i;
        issue_tmo   = (state == ISSUE) && !dbg_ready_i && (tmo_cnt == TMO_LAST);
        tx_tick     = (tx_cnt == BIT_LAST);
        tx_last     = (state == RESP) && tx_tick && (tx_bit == 4'd9) && (tx_idx == 3'd4);
        case (tx_idx)
            3'd0:    next_tx_byte = rsp_data[7:0];
            3'd1:    next_tx_byte = rsp_data[15:8];
            3'd2:    next_tx_byte = rsp_data[23:16];
            3'd3:    next_tx_byte = rsp_data[31:24];
            default: next_tx_byte = 8'h00;
        endcase
        case (state)
            IDLE:  if (rx_done) state_next = RECV;
            RECV: begin
                if (rx_ferr || gap_expired) state_next = IDLE;
                else if (rx_done && byte_cnt == 4'd8) state_next = (cmd_r != 8'h00) ? ISSUE : IDLE;
            end
            ISSUE: if (issue_ok || issue_tmo) state_next = RESP;
            RESP:  if (tx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_o     <= 1'b0;
            uart_tx_o  <= 1'b1;
            dbg_cmd_o  <= '0;
            dbg_addr_o <= '0;
            dbg_data_o <= '0;
            byte_cnt   <= '0;
            cmd_r      <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            tx_cnt     <= '0;
            rsp_data   <= '0;
            tx_shift   <= '1;
            tx_bit     <= '0;
            tx_idx     <= '0;
        end else begin
            busy_o <= (state_next != IDLE);
            if (state != RECV || rx_done) gap_cnt <= '0;
            else if (rx_state == RX_IDLE) gap_cnt <= gap_cnt + 32'd1;

            if (state == IDLE && rx_done) begin
                cmd_r    <= rx_shift;
                byte_cnt <= 4'd1;
            end
            // Little-endian fields fill from the top so byte 1/5 lands in bits [7:0].
            if (state == RECV && rx_done) begin
                byte_cnt <= byte_cnt + 4'd1;
                if (byte_cnt <= 4'd4) addr_r <= {rx_shift, addr_r[31:8]};
                else                  data_r <= {rx_shift, data_r[31:8]};
            end
            // Byte 8 is still in rx_shift on the entry edge, so merge it directly.
            if (state == RECV && state_next == ISSUE) begin
                dbg_cmd_o  <= cmd_r;
                dbg_addr_o <= addr_r;
                dbg_data_o <= {rx_shift, data_r[31:8]};
                tmo_cnt    <= '0;
            end
            if (state == ISSUE) tmo_cnt <= tmo_cnt + 32'd1;

            if (issue_ok || issue_tmo) begin
                dbg_cmd_o <= 8'h00;
                rsp_data  <= issue_ok ? dbg_data_i : 32'hFFFF_FFFF;
                tx_shift  <= {1'b1, (issue_ok ? 8'h00 : 8'hEE), 1'b0};
                uart_tx_o <= 1'b0;
                tx_cnt    <= '0;
                tx_bit    <= '0;
                tx_idx    <= '0;
            end

            if (state == RESP) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        if (tx_idx != 3'd4) begin
                            tx_idx    <= tx_idx + 3'd1;
                            tx_shift  <= {1'b1, next_tx_byte, 1'b0};
                            uart_tx_o <= 1'b0;
                            tx_bit    <= '0;
                        end
                    end else begin
                        tx_shift  <= {1'b1, tx_shift[9:1]};
                        uart_tx_o <= tx_shift[1];
                        tx_bit    <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge at 10 clocks per bit: frames are driven on RX, a
// frame-level model predicts debug commands and response bytes.
module tb_uart_dbg_bridge;
    localparam int CPB = 10;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        uart_rx_i;
    logic        uart_tx_o;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // {cmd[119:112], addr[111:80], data[79:48], ready_delay[47:32], rdata[31:0]}
    logic [119:0] exp_q[$];
    logic [7:0]   tx_q[$];

    always #5 clk = ~clk;

    uart_dbg_bridge #(
        .CLK_FREQ(1000000), .BAUD(100000), .DBG_TIMEOUT(TMO), .FRAME_GAP_BITS(20)
    ) dut (
        .clk(clk), .rstn_i(rstn_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
        .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
        .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i), .busy_o(busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model: delay 0 means the bench never answers, so the bridge must time out.
    task automatic expect_frame(input logic [71:0] f, input int delay, input logic [31:0] rdata,
                                input bit with_resp);
        logic [7:0]  b[9];
        logic [31:0] addr, data, rd;
        logic [7:0]  status;
        for (int i = 0; i < 9; i++) b[i] = f[71-8*i -: 8];
        addr = 0;
        data = 0;
        for (int i = 0; i < 4; i++) begin
            addr = addr + (32'(b[1+i]) << (8*i));
            data = data + (32'(b[5+i]) << (8*i));
        end
        if (b[0] != 8'h00) begin
            exp_q.push_back({b[0], addr, data, 16'(delay), rdata});
            if (with_resp) begin
                status = (delay == 0) ? 8'hEE : 8'h00;
                rd     = (delay == 0) ? 32'hFFFF_FFFF : rdata;
                tx_q.push_back(status);
                for (int k = 0; k < 4; k++) tx_q.push_back(rd[8*k +: 8]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        uart_rx_i = v;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic send_frame(input logic [71:0] f);
        for (int i = 0; i < 9; i++) send_byte(f[71-8*i -: 8], 1'b1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && busy_o; i++) idle(1);
        chk({name, "_busy_fall"}, 32'(busy_o), 0);
        idle(20);
        chk({name, "_cmd_q_left"}, 32'(exp_q.size()), 0);
        chk({name, "_tx_q_left"}, 32'(tx_q.size()), 0);
    endtask

    task automatic reset_check(input string name);
        chk({name, "_tx"}, 32'(uart_tx_o), 1);
        chk({name, "_cmd"}, 32'(dbg_cmd_o), 0);
        chk({name, "_addr"}, dbg_addr_o, 0);
        chk({name, "_data"}, dbg_data_o, 0);
        chk({name, "_busy"}, 32'(busy_o), 0);
    endtask

    // Debug-port responder and command checker.
    initial begin
        int           hi;
        int           exp_len;
        logic [119:0] cur;
        logic         unexp, unstable;
        hi = 0; cur = '0; unexp = 0; unstable = 0;
        dbg_ready_i = 1'b0;
        dbg_data_i  = '0;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                hi = 0;
                dbg_ready_i = 1'b0;
            end else if (dbg_cmd_o != 8'h00) begin
                hi++;
                if (hi == 1) begin
                    unstable = 0;
                    if (exp_q.size() == 0) begin
                        unexp = 1;
                        cur   = '0;
                        chk("cmd_unexpected", 32'(dbg_cmd_o), 0);
                    end else begin
                        unexp = 0;
                        cur   = exp_q.pop_front();
                        chk("cmd", 32'(dbg_cmd_o), 32'(cur[119:112]));
                        chk("addr", dbg_addr_o, cur[111:80]);
                        chk("data", dbg_data_o, cur[79:48]);
                    end
                end else if (!unexp && (dbg_cmd_o !== cur[119:112] || dbg_addr_o !== cur[111:80] ||
                                        dbg_data_o !== cur[79:48])) begin
                    unstable = 1;
                end
                dbg_data_i  = cur[31:0];
                dbg_ready_i = !unexp && (cur[47:32] != 16'd0) && (hi == int'(cur[47:32]));
            end else begin
                if (hi > 0 && !unexp) begin
                    exp_len = (cur[47:32] == 16'd0) ? TMO : int'(cur[47:32]);
                    chk("cmd_len", 32'(hi), 32'(exp_len));
                    chk("cmd_stable", 32'(unstable), 0);
                end
                hi = 0;
                dbg_ready_i = 1'b0;
            end
        end
    end

    // UART TX decoder, sampling each bit near its centre.
    initial begin
        int         tcnt;
        logic       tbusy, tprev;
        logic [7:0] tbyte, texp;
        tcnt = 0; tbusy = 0; tprev = 1; tbyte = '0;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                tbusy = 0;
            end else if (!tbusy) begin
                if (tprev && !uart_tx_o) begin
                    tbusy = 1;
                    tcnt  = 0;
                end
            end else begin
                tcnt++;
                if (tcnt == 4) chk("tx_start", 32'(uart_tx_o), 0);
                else if (tcnt >= 14 && tcnt <= 84 && tcnt % 10 == 4) tbyte[(tcnt-14)/10] = uart_tx_o;
                else if (tcnt == 94) begin
                    chk("tx_stop", 32'(uart_tx_o), 1);
                    chk("tx_busy", 32'(busy_o), 1);
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected", 32'(tx_q.size()), 1);
                    end else begin
                        texp = tx_q.pop_front();
                        chk("tx_byte", 32'(tbyte), 32'(texp));
                    end
                    tbusy = 0;
                end
            end
            tprev = uart_tx_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i    = 1'b0;
        uart_rx_i = 1'b1;
        idle(3);
        reset_check("reset");
        rstn_i = 1'b1;
        idle(5);

        expect_frame(72'h02_00_10_00_00_EF_BE_AD_DE, 3, 32'hDEAD_BEEF, 1);
        send_frame(72'h02_00_10_00_00_EF_BE_AD_DE);
        wait_idle("write");
        chk("write_addr_lit", dbg_addr_o, 32'h0000_1000);
        chk("write_data_lit", dbg_data_o, 32'hDEAD_BEEF);
        chk("write_cmd_idle", 32'(dbg_cmd_o), 0);

        expect_frame(72'h01_04_00_00_00_00_00_00_00, 5, 32'h1234_5678, 1);
        send_frame(72'h01_04_00_00_00_00_00_00_00);
        wait_idle("read");
        chk("read_addr_lit", dbg_addr_o, 32'h0000_0004);

        expect_frame(72'h03_20_00_00_00_55_00_00_00, 0, 32'h0, 1);
        send_frame(72'h03_20_00_00_00_55_00_00_00);
        wait_idle("timeout");
        chk("timeout_addr_lit", dbg_addr_o, 32'h0000_0020);

        send_byte(8'h09, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(250);
        chk("gap_busy", 32'(busy_o), 0);
        expect_frame(72'h04_40_00_00_00_01_02_03_04, 2, 32'h0BAD_F00D, 1);
        send_frame(72'h04_40_00_00_00_01_02_03_04);
        wait_idle("gap");
        chk("gap_data_lit", dbg_data_o, 32'h0403_0201);

        send_byte(8'h0A, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'(4 + i), 1'b1);
        idle(300);
        chk("ferr_busy", 32'(busy_o), 0);
        chk("ferr_cmd_q", 32'(exp_q.size()), 0);

        send_frame(72'h00_11_22_33_44_55_66_77_88);
        idle(2);
        chk("nop_busy", 32'(busy_o), 0);
        chk("nop_cmd", 32'(dbg_cmd_o), 0);
        chk("nop_tx", 32'(uart_tx_o), 1);
        idle(20);

        expect_frame(72'h05_00_20_00_00_00_00_00_00, 2, 32'hA5A5_5A5A, 1);
        send_frame(72'h05_00_20_00_00_00_00_00_00);
        send_byte(8'h06, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_idle("overlap");
        expect_frame(72'h06_80_00_00_00_AA_BB_CC_DD, 1, 32'h600D_CAFE, 1);
        send_frame(72'h06_80_00_00_00_AA_BB_CC_DD);
        wait_idle("after_overlap");

        expect_frame(72'h07_10_00_00_00_01_00_00_00, 0, 32'h0, 0);
        send_frame(72'h07_10_00_00_00_01_00_00_00);
        idle(50);
        chk("rst_issue_cmd", 32'(dbg_cmd_o), 32'h07);
        rstn_i = 1'b0;
        #1;
        reset_check("rst_issue");
        idle(3);
        rstn_i = 1'b1;
        idle(5);

        expect_frame(72'h08_30_00_00_00_02_00_00_00, 2, 32'h0, 0);
        tx_q.push_back(8'h00);
        send_frame(72'h08_30_00_00_00_02_00_00_00);
        for (int i = 0; i < 1000 && tx_q.size() != 0; i++) idle(1);
        chk("rst_tx_first", 32'(tx_q.size()), 0);
        idle(40);
        chk("rst_tx_mid", 32'(uart_tx_o), 0);
        rstn_i = 1'b0;
        #1;
        reset_check("rst_tx");
        idle(3);
        rstn_i = 1'b1;
        idle(5);

        expect_frame(72'h0B_EF_BE_00_00_78_56_34_12, 4, 32'hCAFE_F00D, 1);
        send_frame(72'h0B_EF_BE_00_00_78_56_34_12);
        wait_idle("final");
        chk("final_addr_lit", dbg_addr_o, 32'h0000_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
